// File: rtl/binary_mul_pipe_if.sv
// binary_mul_pipe_if
// Groups the operand/result signals of the pipelined multiplier.
//   en        : clock enable, 0 freezes the whole pipeline
//   in_valid  : A, B and the mode bits carry a transaction this cycle
//   a_signed  : 1 = A is two's complement, 0 = unsigned
//   b_signed  : 1 = B is two's complement, 0 = unsigned
//   A, B      : WIDTH-bit operands
//   out_valid : P holds a new result this cycle
//   P         : 2*WIDTH-bit exact product
// master drives operands and reads results; slave is the multiplier side.
interface binary_mul_pipe_if #(
  parameter int WIDTH = 8
);
  logic                 en;
  logic                 in_valid;
  logic                 a_signed;
  logic                 b_signed;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 out_valid;
  logic [2*WIDTH-1:0]   P;

  modport master (
    output en, in_valid, a_signed, b_signed, A, B,
    input  out_valid, P
  );

  modport slave (
    input  en, in_valid, a_signed, b_signed, A, B,
    output out_valid, P
  );
endinterface

// File: rtl/binary_mul_pipe.sv
// binary_mul_pipe
// Parametrised pipelined array multiplier with per-transaction signed/unsigned
// operand selection and an exact 2*WIDTH-bit product.
//   clk   : clock, all logic on the rising edge
//   rst   : synchronous active-high reset, priority over en
//   mulIf : slave side of binary_mul_pipe_if (en, in_valid, modes, A, B,
//           out_valid, P)
// Latency is NSTAGES enabled edges; one transaction per enabled cycle.
module binary_mul_pipe #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic            clk,
  input  logic            rst,
  binary_mul_pipe_if.slave mulIf
);

  localparam int NSTAGES = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int PW      = 2 * WIDTH;

  // Inputs seen by each stage: index 0 comes from the interface, index k>0
  // from the register bank of stage k-1.
  logic [PW-1:0]    stSum     [NSTAGES];
  logic [WIDTH:0]   stAExt    [NSTAGES];
  logic [WIDTH-1:0] stB       [NSTAGES];
  logic             stBSigned [NSTAGES];
  logic             stValid   [NSTAGES];

  logic [PW-1:0]    P_q;
  logic             outValid_q;

  // The A mode bit is consumed here: it only decides the extension bit, so
  // later stages carry the already-extended multiplicand instead.
  assign stSum[0]     = '0;
  assign stAExt[0]    = {mulIf.a_signed & mulIf.A[WIDTH-1], mulIf.A};
  assign stB[0]       = mulIf.B;
  assign stBSigned[0] = mulIf.b_signed;
  assign stValid[0]   = mulIf.in_valid;

  assign mulIf.P         = P_q;
  assign mulIf.out_valid = outValid_q;

  genvar k;
  for (k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int LO = k * ROWS_PER_STAGE;
    localparam int HI = (LO + ROWS_PER_STAGE > WIDTH) ? WIDTH : LO + ROWS_PER_STAGE;

    logic [PW-1:0] sum_d;
    logic [PW-1:0] row;

    // Add this stage's partial-product rows into the running sum. Arithmetic
    // wraps modulo 2^PW, which is exact because every mode's product fits.
    // The MSB row of a signed B carries weight -2^(WIDTH-1), so it is
    // subtracted instead of added.
    always_comb begin
      sum_d = stSum[k];
      row   = '0;
      for (int j = LO; j < HI; j++) begin
        row = {{(WIDTH-1){stAExt[k][WIDTH]}}, stAExt[k]} << j;
        if (stB[k][j]) begin
          if ((j == WIDTH - 1) && stBSigned[k]) begin
            sum_d = sum_d - row;
          end else begin
            sum_d = sum_d + row;
          end
        end
      end
    end

    if (k < NSTAGES - 1) begin : g_reg
      logic [PW-1:0]    sum_q;
      logic [WIDTH:0]   aExt_q;
      logic [WIDTH-1:0] b_q;
      logic             bSigned_q;
      logic             valid_q;

      // Intermediate stage register; bubbles advance with valid_q=0.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q     <= '0;
          aExt_q    <= '0;
          b_q       <= '0;
          bSigned_q <= 1'b0;
          valid_q   <= 1'b0;
        end else if (mulIf.en) begin
          sum_q     <= sum_d;
          aExt_q    <= stAExt[k];
          b_q       <= stB[k];
          bSigned_q <= stBSigned[k];
          valid_q   <= stValid[k];
        end
      end

      assign stSum[k+1]     = sum_q;
      assign stAExt[k+1]    = aExt_q;
      assign stB[k+1]       = b_q;
      assign stBSigned[k+1] = bSigned_q;
      assign stValid[k+1]   = valid_q;
    end else begin : g_out
      // Last stage writes the product; P keeps its old value for bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          P_q        <= '0;
          outValid_q <= 1'b0;
        end else if (mulIf.en) begin
          outValid_q <= stValid[k];
          if (stValid[k]) begin
            P_q <= sum_d;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_mul_pipe.sv
// tb_binary_mul_pipe
// Directed and randomized checks of binary_mul_pipe in two configurations:
// WIDTH=8/ROWS_PER_STAGE=2 (four stages) and WIDTH=5/ROWS_PER_STAGE=5 (one
// stage). Expected products come from integer arithmetic on the operand
// values; expected timing comes from a queue of in-flight results.
module tb_binary_mul_pipe;

  localparam int NS8 = 4;
  localparam int NS5 = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  binary_mul_pipe_if #(.WIDTH(8)) bus8 ();
  binary_mul_pipe_if #(.WIDTH(5)) bus5 ();

  binary_mul_pipe #(.WIDTH(8), .ROWS_PER_STAGE(2)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .mulIf (bus8)
  );

  binary_mul_pipe #(.WIDTH(5), .ROWS_PER_STAGE(5)) dut5 (
    .clk   (clk),
    .rst   (rst),
    .mulIf (bus5)
  );

  int assertCount = 0;
  int failCount   = 0;

  // In-flight results per configuration, plus the modelled output register.
  bit          m8V [NS8];
  logic [15:0] m8P [NS8];
  bit          m8OutV;
  logic [15:0] m8Out;
  bit          m5V [NS5];
  logic [9:0]  m5P [NS5];
  bit          m5OutV;
  logic [9:0]  m5Out;

  // Exact product of two w-bit operands interpreted per their mode bits,
  // returned modulo 2^(2w).
  function automatic logic [31:0] refProd(input int w, input bit aS, input bit bS,
                                          input logic [31:0] a, input logic [31:0] b);
    longint av;
    longint bv;
    longint p;
    av = longint'(a);
    bv = longint'(b);
    if (aS && a[w-1]) av = av - (longint'(1) << w);
    if (bS && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Advance the reference models by one clock edge using the inputs that
  // are about to be sampled.
  task automatic stepModels();
    if (rst) begin
      for (int i = 0; i < NS8; i++) begin
        m8V[i] = 1'b0;
        m8P[i] = '0;
      end
      for (int i = 0; i < NS5; i++) begin
        m5V[i] = 1'b0;
        m5P[i] = '0;
      end
      m8OutV = 1'b0;
      m8Out  = '0;
      m5OutV = 1'b0;
      m5Out  = '0;
    end else begin
      if (bus8.en) begin
        for (int i = NS8 - 1; i > 0; i--) begin
          m8V[i] = m8V[i-1];
          m8P[i] = m8P[i-1];
        end
        m8V[0] = bus8.in_valid;
        m8P[0] = 16'(refProd(8, bus8.a_signed, bus8.b_signed, 32'(bus8.A), 32'(bus8.B)));
        m8OutV = m8V[NS8-1];
        if (m8OutV) m8Out = m8P[NS8-1];
      end
      if (bus5.en) begin
        for (int i = NS5 - 1; i > 0; i--) begin
          m5V[i] = m5V[i-1];
          m5P[i] = m5P[i-1];
        end
        m5V[0] = bus5.in_valid;
        m5P[0] = 10'(refProd(5, bus5.a_signed, bus5.b_signed, 32'(bus5.A), 32'(bus5.B)));
        m5OutV = m5V[NS5-1];
        if (m5OutV) m5Out = m5P[NS5-1];
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit v, input bit aS, input bit bS,
                               input logic [7:0] a, input logic [7:0] b);
    bus8.en       = en;
    bus8.in_valid = v;
    bus8.a_signed = aS;
    bus8.b_signed = bS;
    bus8.A        = a;
    bus8.B        = b;
  endtask

  task automatic applyStimulus5(input bit en, input bit v, input bit aS, input bit bS,
                                input logic [4:0] a, input logic [4:0] b);
    bus5.en       = en;
    bus5.in_valid = v;
    bus5.a_signed = aS;
    bus5.b_signed = bS;
    bus5.A        = a;
    bus5.B        = b;
  endtask

  // One clock edge: update models, wait past the edge, compare both DUTs.
  task automatic tick();
    stepModels();
    @(posedge clk);
    #1;
    checkOutput("model_ov8", 32'(bus8.out_valid), 32'(m8OutV));
    checkOutput("model_p8", 32'(bus8.P), 32'(m8Out));
    checkOutput("model_ov5", 32'(bus5.out_valid), 32'(m5OutV));
    checkOutput("model_p5", 32'(bus5.P), 32'(m5Out));
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus5(1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00);
    tick();
    tick();
    checkOutput("reset_ov8", 32'(bus8.out_valid), 32'd0);
    checkOutput("reset_p8", 32'(bus8.P), 32'd0);
    checkOutput("reset_ov5", 32'(bus5.out_valid), 32'd0);
    checkOutput("reset_p5", 32'(bus5.P), 32'd0);
    rst = 1'b0;

    $display("[TB] signed x signed");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 8'h80);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("ss_early_ov", 32'(bus8.out_valid), 32'd0);
    tick();
    checkOutput("ss_ov", 32'(bus8.out_valid), 32'd1);
    checkOutput("ss_p", 32'(bus8.P), 32'h4000);
    tick();
    checkOutput("ss_ov_one_cycle", 32'(bus8.out_valid), 32'd0);
    checkOutput("ss_p_hold", 32'(bus8.P), 32'h4000);

    $display("[TB] unsigned and mixed modes");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("uu_ov", 32'(bus8.out_valid), 32'd1);
    checkOutput("uu_p", 32'(bus8.P), 32'hFE01);
    tick();
    checkOutput("su_ov", 32'(bus8.out_valid), 32'd1);
    checkOutput("su_p", 32'(bus8.P), 32'hFF01);
    tick();
    checkOutput("su_after_ov", 32'(bus8.out_valid), 32'd0);

    $display("[TB] back-to-back random with one gap");
    seen = 0;
    for (int i = 0; i < 17; i++) begin
      if (i == 7) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      end else begin
        applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom), 8'($urandom));
      end
      tick();
      if (bus8.out_valid) seen++;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < NS8 + 1; i++) begin
      tick();
      if (bus8.out_valid) seen++;
    end
    checkOutput("b2b_count", 32'(seen), 32'd16);

    $display("[TB] stall");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd5);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("stall_early_ov", 32'(bus8.out_valid), 32'd0);
    tick();
    checkOutput("stall_ov", 32'(bus8.out_valid), 32'd1);
    checkOutput("stall_p", 32'(bus8.P), 32'd15);
    tick();
    checkOutput("stall_no_junk_ov", 32'(bus8.out_valid), 32'd0);
    checkOutput("stall_no_junk_p", 32'(bus8.P), 32'd15);

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
      tick();
    end
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("rst_ov", 32'(bus8.out_valid), 32'd0);
    checkOutput("rst_p", 32'(bus8.P), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 8'hFE);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("rst_no_stale_ov", 32'(bus8.out_valid), 32'd0);
    checkOutput("rst_no_stale_p", 32'(bus8.P), 32'd0);
    tick();
    checkOutput("post_rst_ov", 32'(bus8.out_valid), 32'd1);
    checkOutput("post_rst_p", 32'(bus8.P), 32'hFFF2);

    $display("[TB] single-stage configuration");
    applyStimulus5(1'b1, 1'b1, 1'b1, 1'b1, 5'h10, 5'h0F);
    tick();
    checkOutput("ns1_ov", 32'(bus5.out_valid), 32'd1);
    checkOutput("ns1_p", 32'(bus5.P), 32'h310);
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        applyStimulus5(1'b1, 1'b1, 1'b1, 1'b1, 5'(a), 5'(b));
        tick();
      end
    end
    applyStimulus5(1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00);
    tick();
    checkOutput("ns1_idle_ov", 32'(bus5.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
